// File: rtl/fwd_pkg.sv
// Shared defaults and helpers for the operand forwarding / hazard unit.
// Optional build macro used by this slice: FWD_LL_BYPASS_EN.
package fwd_pkg;

  localparam int unsigned DEF_NUM_RPORTS = 2;
  localparam int unsigned DEF_NUM_STAGES = 3;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_AREG_W     = 5;

  // Architectural register 0 reads as zero and is never tracked as pending.
  localparam int unsigned REG_ZERO = 0;

  // Lowest bit of element idx in a flattened bus of width-bit elements.
  function automatic int unsigned lo_bit(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// Decode-side bundle for forward_scoreboard: read ports, stage results,
// decode destination / issue and long-latency writeback.
// Handshake: there is no valid/ready pair here; decode treats `waiting` as
// a combinational stall and must not raise `issue` in a cycle where
// `waiting` is 1 (the scoreboard ignores such an issue).
interface forward_scoreboard_if
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_RPORTS = DEF_NUM_RPORTS,
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned AREG_W     = DEF_AREG_W
);

  logic                           empty;
  logic [NUM_RPORTS*AREG_W-1:0]   raddr;
  logic [NUM_RPORTS-1:0]          early_need;
  logic [NUM_RPORTS*AREG_W-1:0]   rf_raddr;
  logic [NUM_RPORTS*DATA_W-1:0]   rf_rdata;
  logic [NUM_RPORTS*DATA_W-1:0]   rdata;

  logic [NUM_STAGES-1:0]          stg_valid;
  logic [NUM_STAGES-1:0]          stg_wen;
  logic [NUM_STAGES*AREG_W-1:0]   stg_waddr;
  logic [NUM_STAGES*DATA_W-1:0]   stg_wdata;
  logic [NUM_STAGES-1:0]          stg_data_ok;

  logic                           id_wen;
  logic [AREG_W-1:0]              id_waddr;
  logic                           issue;
  logic                           issue_ll;

  logic                           ll_done;
  logic [AREG_W-1:0]              ll_waddr;
  logic [DATA_W-1:0]              ll_wdata;

  logic                           waiting;
  logic [(2**AREG_W)-1:0]         pending;

  // Pipeline / decode / register-file side.
  modport master (
    output empty, raddr, early_need, rf_rdata,
    output stg_valid, stg_wen, stg_waddr, stg_wdata, stg_data_ok,
    output id_wen, id_waddr, issue, issue_ll,
    output ll_done, ll_waddr, ll_wdata,
    input  rf_raddr, rdata, waiting, pending
  );

  // Forwarding / hazard unit side.
  modport slave (
    input  empty, raddr, early_need, rf_rdata,
    input  stg_valid, stg_wen, stg_waddr, stg_wdata, stg_data_ok,
    input  id_wen, id_waddr, issue, issue_ll,
    input  ll_done, ll_waddr, ll_wdata,
    output rf_raddr, rdata, waiting, pending
  );

endinterface

// File: rtl/fwd_port_sel.sv
// One decode read port: finds the youngest in-flight stage writing the
// source register, muxes its result over the register file, and raises a
// per-port stall when that operand is not yet usable.
// With FWD_LL_BYPASS_EN a pending long-latency result that writes back in
// this very cycle is forwarded instead of stalling.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned AREG_W     = DEF_AREG_W
) (
  input  logic [AREG_W-1:0]            raddr,
  input  logic                         early_need,
  input  logic [DATA_W-1:0]            rf_rdata,
  input  logic [NUM_STAGES-1:0]        stg_valid,
  input  logic [NUM_STAGES-1:0]        stg_wen,
  input  logic [NUM_STAGES*AREG_W-1:0] stg_waddr,
  input  logic [NUM_STAGES*DATA_W-1:0] stg_wdata,
  input  logic [NUM_STAGES-1:0]        stg_data_ok,
  input  logic                         pend_bit,
`ifdef FWD_LL_BYPASS_EN
  input  logic                         ll_done,
  input  logic [AREG_W-1:0]            ll_waddr,
  input  logic [DATA_W-1:0]            ll_wdata,
`endif
  output logic [DATA_W-1:0]            rdata,
  output logic                         stall
);

  logic [NUM_STAGES-1:0] match;
  logic                  any_match;
  logic                  win_ok;
  logic [DATA_W-1:0]     win_data;
  logic                  ll_hit;
  logic [DATA_W-1:0]     ll_data;

  // Per-stage match; register 0 never matches so it always reads the RF.
  always_comb begin
    match = '0;
    for (int s = 0; s < int'(NUM_STAGES); s++) begin
      match[s] = stg_valid[s] && stg_wen[s] &&
                 (raddr != AREG_W'(REG_ZERO)) &&
                 (raddr == stg_waddr[lo_bit(s, AREG_W) +: AREG_W]);
    end
  end

  // Priority select: walk oldest to youngest so the lowest index wins.
  always_comb begin
    any_match = 1'b0;
    win_ok    = 1'b1;
    win_data  = rf_rdata;
    for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
      if (match[s]) begin
        any_match = 1'b1;
        win_ok    = stg_data_ok[s];
        win_data  = stg_wdata[lo_bit(s, DATA_W) +: DATA_W];
      end
    end
  end

  // Same-cycle long-latency writeback hit (only meaningful when pending).
  always_comb begin
`ifdef FWD_LL_BYPASS_EN
    ll_hit  = pend_bit && ll_done && (ll_waddr == raddr);
    ll_data = ll_wdata;
`else
    ll_hit  = 1'b0;
    ll_data = rf_rdata;
`endif
  end

  // Operand mux and per-port stall.
  always_comb begin
    rdata = rf_rdata;
    if (any_match) begin
      rdata = win_data;
    end else if (ll_hit) begin
      rdata = ll_data;
    end
    stall = (any_match && (!win_ok || early_need)) ||
            (!any_match && pend_bit && !ll_hit);
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Decode-stage operand forwarding and hazard unit with a pending-write
// scoreboard for out-of-order long-latency (mul/div) writebacks.
// Build macro: FWD_LL_BYPASS_EN forwards a long-latency result to decode
// in the cycle it writes back instead of stalling one extra cycle.
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_RPORTS = DEF_NUM_RPORTS,
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned AREG_W     = DEF_AREG_W
) (
  input  logic                clk,
  input  logic                rst_p,
  forward_scoreboard_if.slave bus
);

  localparam int unsigned NUM_REGS = 2 ** AREG_W;

  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;
  logic [NUM_RPORTS-1:0] port_stall;
  logic                  waw_stall;
  logic                  stall_any;
  logic                  set_en;

  assign bus.rf_raddr = bus.raddr;
  assign bus.pending  = pending_q;

  genvar p;
  generate
    for (p = 0; p < int'(NUM_RPORTS); p++) begin : g_port
      logic [AREG_W-1:0] port_addr;
      assign port_addr = bus.raddr[lo_bit(p, AREG_W) +: AREG_W];

      fwd_port_sel #(
        .NUM_STAGES (NUM_STAGES),
        .DATA_W     (DATA_W),
        .AREG_W     (AREG_W)
      ) u_port_sel (
        .raddr       (port_addr),
        .early_need  (bus.early_need[p]),
        .rf_rdata    (bus.rf_rdata[lo_bit(p, DATA_W) +: DATA_W]),
        .stg_valid   (bus.stg_valid),
        .stg_wen     (bus.stg_wen),
        .stg_waddr   (bus.stg_waddr),
        .stg_wdata   (bus.stg_wdata),
        .stg_data_ok (bus.stg_data_ok),
        .pend_bit    (pending_q[port_addr]),
`ifdef FWD_LL_BYPASS_EN
        .ll_done     (bus.ll_done),
        .ll_waddr    (bus.ll_waddr),
        .ll_wdata    (bus.ll_wdata),
`endif
        .rdata       (bus.rdata[lo_bit(p, DATA_W) +: DATA_W]),
        .stall       (port_stall[p])
      );
    end
  endgenerate

  // Combine port stalls with the write-after-write hazard on a pending dest.
  always_comb begin
    waw_stall   = bus.id_wen && (bus.id_waddr != AREG_W'(REG_ZERO)) &&
                  pending_q[bus.id_waddr];
    stall_any   = (|port_stall) || waw_stall;
    bus.waiting = !bus.empty && stall_any;
    set_en      = bus.issue && !bus.empty && bus.issue_ll &&
                  (bus.id_waddr != AREG_W'(REG_ZERO)) && !bus.waiting;
  end

  // Scoreboard next state: clear on writeback, then set on issue so a
  // younger issue to the same register wins; r0 is never pending.
  always_comb begin
    pending_d = pending_q;
    if (bus.ll_done) begin
      pending_d[bus.ll_waddr] = 1'b0;
    end
    if (set_en) begin
      pending_d[bus.id_waddr] = 1'b1;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  // Scoreboard register; reset drops all outstanding long-latency writes.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: a small register-file model
// feeds rf_rdata; expected values are queued as each step is driven and
// popped when the outputs are sampled on the falling edge.
module tb_forward_scoreboard;

  localparam int NP = 2;
  localparam int NS = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst_p;

  int n_checks;
  int n_pass;

  logic [31:0] exp_q[$];
  logic [31:0] rf [32];

  forward_scoreboard_if #(
    .NUM_RPORTS (NP), .NUM_STAGES (NS), .DATA_W (DW), .AREG_W (AW)
  ) bus ();

  forward_scoreboard #(
    .NUM_RPORTS (NP), .NUM_STAGES (NS), .DATA_W (DW), .AREG_W (AW)
  ) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  // Clock and register file model (initialised while reset is high).
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_p) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000 + i;
    end else if (bus.ll_done && bus.ll_waddr != 5'd0) begin
      rf[bus.ll_waddr] <= bus.ll_wdata;
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bus.rf_rdata[p*DW +: DW] = rf[bus.rf_raddr[p*AW +: AW]];
    end
  end

  // Protocol: decode never issues while stalled.
  always @(negedge clk) begin
    if (!rst_p && bus.issue) begin
      n_checks++;
      assert (bus.waiting === 1'b0) n_pass++;
      else $error("FAIL issue_while_waiting: observed waiting=%0b expected 0", bus.waiting);
    end
  end

  // Driver tasks.
  task automatic idle();
    bus.empty       = 1'b0;
    bus.raddr       = '0;
    bus.early_need  = '0;
    bus.stg_valid   = '0;
    bus.stg_wen     = '0;
    bus.stg_waddr   = '0;
    bus.stg_wdata   = '0;
    bus.stg_data_ok = '0;
    bus.id_wen      = 1'b0;
    bus.id_waddr    = '0;
    bus.issue       = 1'b0;
    bus.issue_ll    = 1'b0;
    bus.ll_done     = 1'b0;
    bus.ll_waddr    = '0;
    bus.ll_wdata    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_stage(input int s, input logic [4:0] a, input logic [31:0] d, input logic ok);
    bus.stg_valid[s]          = 1'b1;
    bus.stg_wen[s]            = 1'b1;
    bus.stg_waddr[s*AW +: AW] = a;
    bus.stg_wdata[s*DW +: DW] = d;
    bus.stg_data_ok[s]        = ok;
  endtask

  task automatic set_port(input int p, input logic [4:0] a, input logic early);
    bus.raddr[p*AW +: AW] = a;
    bus.early_need[p]     = early;
  endtask

  task automatic issue_ll_to(input logic [4:0] a);
    bus.id_wen   = 1'b1;
    bus.id_waddr = a;
    bus.issue    = 1'b1;
    bus.issue_ll = 1'b1;
  endtask

  task automatic ll_wb(input logic [4:0] a, input logic [31:0] d);
    bus.ll_done  = 1'b1;
    bus.ll_waddr = a;
    bus.ll_wdata = d;
  endtask

  // Scoreboard.
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  function automatic logic [31:0] wt();
    return {31'b0, bus.waiting};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    rst_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_p = 1'b0;

    // Reset state.
    bus.empty = 1'b1;
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("reset_pending", bus.pending);
    chk("reset_waiting", wt());

    // EX and MA both write r5: youngest (EX) wins.
    next_cycle();
    set_stage(0, 5'd5, 32'h11, 1'b1);
    set_stage(1, 5'd5, 32'h22, 1'b1);
    set_port(0, 5'd5, 1'b0);
    set_port(1, 5'd2, 1'b0);
    push(32'h11); push(32'h1002); push(32'h0);
    @(negedge clk);
    chk("ex_over_ma_rdata0", rd(0));
    chk("rf_pass_rdata1", rd(1));
    chk("ex_over_ma_waiting", wt());

    // Load in EX, data not ready.
    next_cycle();
    set_stage(0, 5'd7, 32'h0, 1'b0);
    set_port(1, 5'd7, 1'b0);
    push(32'h1);
    @(negedge clk);
    chk("load_ex_waiting", wt());

    // Not-ready EX shadows a ready WB for the same register.
    next_cycle();
    set_stage(0, 5'd7, 32'h0, 1'b0);
    set_stage(2, 5'd7, 32'h5555, 1'b1);
    set_port(1, 5'd7, 1'b0);
    push(32'h1);
    @(negedge clk);
    chk("load_shadow_waiting", wt());

    // Load reaches WB with data.
    next_cycle();
    set_stage(2, 5'd7, 32'hABCD, 1'b1);
    set_port(1, 5'd7, 1'b0);
    push(32'h0); push(32'hABCD);
    @(negedge clk);
    chk("load_wb_waiting", wt());
    chk("load_wb_rdata1", rd(1));

    // Early need on an MA match stalls even with data ok.
    next_cycle();
    set_stage(1, 5'd3, 32'h33, 1'b1);
    set_port(0, 5'd3, 1'b1);
    push(32'h1);
    @(negedge clk);
    chk("early_need_waiting", wt());

    next_cycle();
    set_stage(1, 5'd3, 32'h33, 1'b1);
    set_port(0, 5'd3, 1'b0);
    push(32'h0); push(32'h33);
    @(negedge clk);
    chk("late_need_waiting", wt());
    chk("late_need_rdata0", rd(0));

    // Issue a div to r9.
    next_cycle();
    issue_ll_to(5'd9);
    set_port(0, 5'd1, 1'b0);
    set_port(1, 5'd2, 1'b0);
    push(32'h0);
    @(negedge clk);
    chk("div_issue_waiting", wt());

    next_cycle();
    set_port(0, 5'd9, 1'b0);
    push(32'h1); push(32'h1 << 9);
    @(negedge clk);
    chk("div_raw_waiting", wt());
    chk("div_pending", bus.pending);

    next_cycle();
    set_port(0, 5'd9, 1'b0);
    push(32'h1);
    @(negedge clk);
    chk("div_raw_waiting2", wt());

    // Writeback cycle: bypass forwards, otherwise still stalled.
    next_cycle();
    set_port(0, 5'd9, 1'b0);
    ll_wb(5'd9, 32'h999);
`ifdef FWD_LL_BYPASS_EN
    push(32'h0); push(32'h999);
    @(negedge clk);
    chk("ll_bypass_waiting", wt());
    chk("ll_bypass_rdata0", rd(0));
`else
    push(32'h1);
    @(negedge clk);
    chk("ll_done_waiting", wt());
`endif

    next_cycle();
    set_port(0, 5'd9, 1'b0);
    push(32'h0); push(32'h999); push(32'h0);
    @(negedge clk);
    chk("after_ll_waiting", wt());
    chk("after_ll_rdata0", rd(0));
    chk("after_ll_pending", bus.pending);

    // WAW hazard on a pending destination.
    next_cycle();
    issue_ll_to(5'd9);
    @(negedge clk);

    next_cycle();
    bus.id_wen = 1'b1; bus.id_waddr = 5'd9;
    set_port(0, 5'd1, 1'b0);
    set_port(1, 5'd2, 1'b0);
    push(32'h1);
    @(negedge clk);
    chk("waw_waiting", wt());

    next_cycle();
    bus.id_wen = 1'b1; bus.id_waddr = 5'd9;
    ll_wb(5'd9, 32'h777);
    push(32'h1);
    @(negedge clk);
    chk("waw_ll_cycle_waiting", wt());

    next_cycle();
    bus.id_wen = 1'b1; bus.id_waddr = 5'd9;
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("waw_cleared_waiting", wt());
    chk("waw_cleared_pending", bus.pending);

    // Set and clear of r4 in one cycle: set wins.
    next_cycle();
    issue_ll_to(5'd4);
    ll_wb(5'd4, 32'h444);
    @(negedge clk);

    next_cycle();
    push(32'h1 << 4);
    @(negedge clk);
    chk("set_wins_pending", bus.pending);

    next_cycle();
    ll_wb(5'd4, 32'h4444);
    @(negedge clk);

    next_cycle();
    push(32'h0);
    @(negedge clk);
    chk("r4_cleared_pending", bus.pending);

    // r0 reads the RF even when a not-ready stage writes r0.
    next_cycle();
    set_stage(0, 5'd0, 32'hDEAD, 1'b0);
    set_port(0, 5'd0, 1'b1);
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("r0_rdata0", rd(0));
    chk("r0_waiting", wt());

    // Reset mid-operation.
    next_cycle();
    issue_ll_to(5'd12);
    @(negedge clk);

    next_cycle();
    push(32'h1 << 12);
    @(negedge clk);
    chk("r12_pending", bus.pending);

    next_cycle();
    rst_p = 1'b1;
    @(negedge clk);

    next_cycle();
    rst_p = 1'b0;
    ll_wb(5'd12, 32'hC12);
    set_port(0, 5'd12, 1'b0);
    push(32'h0); push(32'h0);
    @(negedge clk);
    chk("midreset_pending", bus.pending);
    chk("midreset_waiting", wt());

    next_cycle();
    push(32'h0);
    @(negedge clk);
    chk("stray_ll_pending", bus.pending);

    // Empty slot suppresses stall and scoreboard set.
    next_cycle();
    bus.empty = 1'b1;
    set_stage(0, 5'd7, 32'h0, 1'b0);
    set_port(1, 5'd7, 1'b1);
    issue_ll_to(5'd6);
    push(32'h0);
    @(negedge clk);
    chk("empty_waiting", wt());

    next_cycle();
    push(32'h0);
    @(negedge clk);
    chk("empty_no_set_pending", bus.pending);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
